dncnt_ctrl: RTL

Sequencing controller for the team's down-counter datapath. Loads a start value, decrements it under a run/pause/stop command set, and flags terminal count. It can optionally auto-reload for periodic operation. It sits between a host or command FSM and any logic that needs a programmable down-count timebase.

---
 rtl/dncnt_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/dncnt_ctrl.sv
// Down-counter sequencing controller: start/stop/pause command set, terminal-count pulse, optional auto-reload.
// Optional tick prescaler built only when DNCNT_PRESCALE_EN is defined.
module dncnt_ctrl #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 4,
  parameter int WRAP_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              mode_reload,
  output logic [WIDTH-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic              tc,
  output logic [WRAP_W-1:0] wrap_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0]  CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]  CNT_ONE  = WIDTH'(1);
  localparam logic [WRAP_W-1:0] WRAP_MAX = {WRAP_W{1'b1}};

  if (WIDTH < 2 || PRESCALE < 2) begin : g_param_check
    $error("dncnt_ctrl: WIDTH and PRESCALE must both be at least 2");
  end

  state_t              state_r, state_s;
  logic [WIDTH-1:0]    count_s, reload_r, reload_s;
  logic [WRAP_W-1:0]   wrap_s;
  logic                mode_r, mode_s, tc_s, tick_s;

`ifdef DNCNT_PRESCALE_EN
  localparam int              PW        = $clog2(PRESCALE);
  localparam logic [PW-1:0]   PRESC_MAX = PW'(PRESCALE - 1);
  localparam logic [PW-1:0]   PRESC_ONE = PW'(1);
  logic [PW-1:0] presc_r, presc_s;
  assign tick_s = (presc_r == PRESC_MAX);
`else
  assign tick_s = 1'b1;
`endif

  // Next-state and datapath update; command priority is stop > start > pause > tick.
  always_comb begin
    state_s  = state_r;
    count_s  = count;
    reload_s = reload_r;
    mode_s   = mode_r;
    wrap_s   = wrap_cnt;
    tc_s     = 1'b0;
`ifdef DNCNT_PRESCALE_EN
    presc_s  = presc_r;
`endif
    if (stop) begin
      // stop while idle leaves the count untouched (it is already zero there)
      if (state_r != S_IDLE) begin
        count_s = CNT_ZERO;
      end else begin
        count_s = count;
      end
      state_s = S_IDLE;
    end else if (start) begin
      reload_s = load_val;
      mode_s   = mode_reload;
      wrap_s   = {WRAP_W{1'b0}};
`ifdef DNCNT_PRESCALE_EN
      presc_s  = {PW{1'b0}};
`endif
      if (load_val == CNT_ZERO) begin
        state_s = S_DONE;
        count_s = CNT_ZERO;
        tc_s    = 1'b1;
      end else begin
        state_s = S_RUN;
        count_s = load_val;
      end
    end else begin
      case (state_r)
        S_RUN: begin
          if (pause) begin
            state_s = S_PAUSE;
          end else begin
`ifdef DNCNT_PRESCALE_EN
            presc_s = tick_s ? {PW{1'b0}} : (presc_r + PRESC_ONE);
`endif
            if (!tick_s) begin
              count_s = count;
            end else if (count > CNT_ONE) begin
              count_s = count - CNT_ONE;
            end else if (mode_r) begin
              count_s = reload_r;
              tc_s    = 1'b1;
              if (wrap_cnt != WRAP_MAX) begin
                wrap_s = wrap_cnt + WRAP_W'(1);
              end else begin
                wrap_s = wrap_cnt;
              end
            end else begin
              count_s = CNT_ZERO;
              tc_s    = 1'b1;
              state_s = S_DONE;
            end
          end
        end
        S_PAUSE: begin
          if (!pause) begin
            state_s = S_RUN;
          end else begin
            state_s = S_PAUSE;
          end
        end
        S_DONE:  state_s = S_DONE;
        S_IDLE:  state_s = S_IDLE;
        default: state_s = S_IDLE;
      endcase
    end
  end

  // State and output registers; busy/done are decoded from the next state so they align with count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= S_IDLE;
      count    <= CNT_ZERO;
      reload_r <= CNT_ZERO;
      mode_r   <= 1'b0;
      wrap_cnt <= {WRAP_W{1'b0}};
      tc       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_r  <= state_s;
      count    <= count_s;
      reload_r <= reload_s;
      mode_r   <= mode_s;
      wrap_cnt <= wrap_s;
      tc       <= tc_s;
      busy     <= (state_s == S_RUN) || (state_s == S_PAUSE);
      done     <= (state_s == S_DONE);
    end
  end

`ifdef DNCNT_PRESCALE_EN
  // Tick prescaler: cleared on start, advances only in RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_r <= {PW{1'b0}};
    end else begin
      presc_r <= presc_s;
    end
  end
`endif

endmodule
